// File: rtl/flex_counter_pkg.sv
// Shared types for the flex up/down counter family: default width, per-edge action
// encoding and the priority decode that turns control inputs into one action.
package flex_counter_pkg;

    localparam int DEFAULT_NUM_BITS = 4;

    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_CLEAR,
        CNT_LOAD,
        CNT_DEC,
        CNT_TERM
    } cnt_action_t;

    // clear > load > enable; a counter parked at its floor ignores enable.
    function automatic cnt_action_t cnt_decode(
        input logic clear,
        input logic load,
        input logic enable,
        input logic at_terminal,
        input logic at_floor
    );
        cnt_action_t act;
        act = CNT_HOLD;
        if (clear) begin
            act = CNT_CLEAR;
        end else if (load) begin
            act = CNT_LOAD;
        end else if (enable) begin
            if (at_floor) begin
                act = CNT_HOLD;
            end else if (at_terminal) begin
                act = CNT_TERM;
            end else begin
                act = CNT_DEC;
            end
        end
        return act;
    endfunction

endpackage

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with one-shot expiry or periodic reload (FLEX_DOWN_COUNTER_AUTO_RELOAD_EN).
// Latency: every output is registered, 1 cycle from the controlling edge.
// Backpressure: none; count_enable gates progress, clear/load always take effect.
module flex_down_counter
    import flex_counter_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_val,
    input  logic                count_enable,
    input  logic                auto_reload,
    output logic [NUM_BITS-1:0] count_out,
    output logic                expired,
    output logic                done_pulse
);

    logic [NUM_BITS-1:0] count_q, count_d;
    logic                expired_q, expired_d;
    logic                done_q, done_d;
    cnt_action_t         action;

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [NUM_BITS-1:0] reload_q, reload_d;
`else
    logic unused_auto_reload;
    assign unused_auto_reload = auto_reload;
`endif

    always_comb begin
        count_d   = count_q;
        expired_d = expired_q;
        done_d    = 1'b0;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        action = cnt_decode(clear, load, count_enable,
                            count_q == NUM_BITS'(1), count_q == '0);
        case (action)
            CNT_CLEAR: begin
                count_d   = '0;
                expired_d = 1'b0;
            end
            CNT_LOAD: begin
                count_d   = load_val;
                expired_d = 1'b0;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
                reload_d  = load_val;
`endif
            end
            CNT_DEC: begin
                count_d = count_q - NUM_BITS'(1);
            end
            CNT_TERM: begin
                done_d = 1'b1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
                // Periodic mode restarts from the stored value; expiry is only for one-shot.
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d   = '0;
                    expired_d = 1'b1;
                end
`else
                count_d   = '0;
                expired_d = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
            done_q    <= done_d;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign count_out  = count_q;
    assign expired    = expired_q;
    assign done_pulse = done_q;

endmodule
